// File: rtl/player_key_decoder.sv
// player_key_decoder: PS/2 make/break decoder driving held left/right/jump levels (WASD_EN adds A/D/W holds)
module player_key_decoder #(
    parameter logic [7:0] LEFT_CODE      = 8'h6B,
    parameter logic [7:0] RIGHT_CODE     = 8'h74,
    parameter logic [7:0] JUMP_CODE      = 8'h75,
    parameter int         TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_error,
    output logic       left,
    output logic       right,
    output logic       jump,
    output logic       seq_busy
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXT     = 2'd1;
    localparam logic [1:0] BRK     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0] state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] arrow, arrow_n;
    logic [2:0] hit;
    logic is_e0, is_f0, is_special, in_ext, plain;

    assign is_e0      = rx_data == 8'hE0;
    assign is_f0      = rx_data == 8'hF0;
    assign plain      = !is_e0 && !is_f0;
    assign is_special = rx_data inside {8'hAA, 8'hFC, 8'h00, 8'hFF};
    assign in_ext     = (state == EXT) || (state == EXT_BRK);
    assign hit        = {rx_data == JUMP_CODE, rx_data == RIGHT_CODE, rx_data == LEFT_CODE};

`ifdef WASD_EN
    logic [2:0] wasd, wasd_n, whit;
    assign whit = {rx_data == 8'h1D, rx_data == 8'h23, rx_data == 8'h1C};
    assign {jump, right, left} = arrow | wasd;
`else
    assign {jump, right, left} = arrow;
`endif

    // Next-state: error beats byte, byte beats timeout; special bytes only act outside extended states
    always_comb begin
        state_n = state;
        cnt_n   = (state == IDLE) ? '0 : cnt + 1'b1;
        arrow_n = arrow;
`ifdef WASD_EN
        wasd_n  = wasd;
`endif
        if (rx_error) begin
            state_n = IDLE;
            cnt_n   = '0;
            arrow_n = '0;
`ifdef WASD_EN
            wasd_n  = '0;
`endif
        end else if (rx_valid) begin
            cnt_n = '0;
            if (is_special && !in_ext) begin
                state_n = IDLE;
                arrow_n = '0;
`ifdef WASD_EN
                wasd_n  = '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        state_n = is_e0 ? EXT : is_f0 ? BRK : IDLE;
`ifdef WASD_EN
                        wasd_n = plain ? wasd | whit : wasd;
`endif
                    end
                    EXT: begin
                        state_n = is_f0 ? EXT_BRK : is_e0 ? EXT : IDLE;
                        arrow_n = plain ? arrow | hit : arrow;
                    end
                    BRK: begin
                        state_n = is_e0 ? EXT_BRK : is_f0 ? BRK : IDLE;
`ifdef WASD_EN
                        wasd_n = plain ? wasd & ~whit : wasd;
`endif
                    end
                    default: begin
                        state_n = plain ? IDLE : EXT_BRK;
                        arrow_n = plain ? arrow & ~hit : arrow;
                    end
                endcase
            end
        end else if (state != IDLE && cnt == LAST) begin
            state_n = IDLE;
            cnt_n   = '0;
        end
    end

    // State, counter and key holds; seq_busy tracks the registered state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            arrow    <= '0;
            seq_busy <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            arrow    <= arrow_n;
            seq_busy <= state_n != IDLE;
        end
    end

`ifdef WASD_EN
    // WASD hold registers, present only in WASD builds
    always_ff @(posedge clk) begin
        if (rst) wasd <= '0;
        else wasd <= wasd_n;
    end
`endif
endmodule

// File: tb/tb_player_key_decoder.sv
// tb_player_key_decoder: randomized and directed checks of player_key_decoder against a prefix-queue model
module tb_player_key_decoder;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic rx_valid = 1'b0;
    logic rx_error = 1'b0;
    logic left, right, jump, seq_busy;

    int tests = 0;
    int failed = 0;

    player_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
        .left(left), .right(right), .jump(jump), .seq_busy(seq_busy)
    );

    always #5 clk = ~clk;

`ifdef WASD_EN
    localparam bit WASD = 1'b1;
`else
    localparam bit WASD = 1'b0;
`endif

    // Model: held keys plus the queue of prefix bytes (E0/F0) seen in the current sequence
    bit m_l, m_r, m_j, m_a, m_d, m_w;
    byte unsigned q[$];
    int idle = 0;

    function automatic bit has(byte unsigned b);
        foreach (q[i]) if (q[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_keys();
        {m_l, m_r, m_j, m_a, m_d, m_w} = '0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            clear_keys();
            q.delete();
            idle = 0;
        end else if (rx_error) begin
            clear_keys();
            q.delete();
            idle = 0;
        end else if (rx_valid) begin
            bit ext, brk;
            byte unsigned b;
            b = rx_data;
            ext = has(8'hE0);
            brk = has(8'hF0);
            idle = 0;
            if (!ext && (b == 8'hAA || b == 8'hFC || b == 8'h00 || b == 8'hFF)) begin
                clear_keys();
                q.delete();
            end else if (b == 8'hE0 || b == 8'hF0) begin
                q.push_back(b);
            end else begin
                if (ext) begin
                    if (b == 8'h6B) m_l = !brk;
                    if (b == 8'h74) m_r = !brk;
                    if (b == 8'h75) m_j = !brk;
                end else if (WASD) begin
                    if (b == 8'h1C) m_a = !brk;
                    if (b == 8'h23) m_d = !brk;
                    if (b == 8'h1D) m_w = !brk;
                end
                q.delete();
            end
        end else if (q.size() != 0) begin
            if (idle == T - 1) begin
                q.delete();
                idle = 0;
            end else idle++;
        end else idle = 0;
    end

    function automatic logic [3:0] expected();
        return {m_l | m_a, m_r | m_d, m_j | m_w, q.size() != 0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic v, input logic e, input logic [7:0] d);
        @(negedge clk);
        check("model", {28'd0, left, right, jump, seq_busy}, {28'd0, expected()});
        rx_valid = v;
        rx_error = e;
        rx_data  = d;
    endtask

    task automatic send(input logic [7:0] d);
        cycle(1'b1, 1'b0, d);
    endtask

    task automatic settle();
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    function automatic logic [31:0] lrj();
        return {29'd0, left, right, jump};
    endfunction

    byte unsigned pool[12] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h1C, 8'h23, 8'h1D, 8'hAA, 8'hFC, 8'h00, 8'hFF};

    initial begin
        repeat (3) @(negedge clk);
        check("reset_out", {28'd0, left, right, jump, seq_busy}, 32'd0);
        rst = 1'b0;

        send(8'hE0); send(8'h6B); settle();
        check("left_make", lrj(), 32'b100);
        send(8'hE0); send(8'hF0); send(8'h6B); settle();
        check("left_break", lrj(), 32'b000);

        send(8'hE0); send(8'h74); send(8'hE0); send(8'h75); settle();
        check("right_jump_make", lrj(), 32'b011);
        for (int i = 0; i < 10; i++) begin
            send(8'hE0); send(8'h74);
            cycle(1'b0, 1'b0, 8'h00);
            check("typematic_right", {31'd0, right}, 32'd1);
        end
        send(8'hE0); send(8'hF0); send(8'h75); settle();
        check("jump_break", lrj(), 32'b010);
        send(8'hE0); send(8'hF0); send(8'h74); settle();

        send(8'h6B); settle();
        check("keypad_make", {30'd0, left, seq_busy}, 32'd0);
        send(8'hF0); send(8'h6B); settle();
        check("keypad_break", {30'd0, left, seq_busy}, 32'd0);

        send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74); settle();
        check("hold_lr", lrj(), 32'b110);
        send(8'hAA); settle();
        check("bat_clear", lrj(), 32'b000);
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74); send(8'hE0);
        cycle(1'b0, 1'b1, 8'h00); settle();
        check("err_clear", {28'd0, left, right, jump, seq_busy}, 32'd0);
        send(8'hE0); send(8'h6B); send(8'hE0);
        cycle(1'b1, 1'b1, 8'h74); settle();
        check("err_wins", {28'd0, left, right, jump, seq_busy}, 32'd0);
        send(8'hE0); send(8'hFF); settle();
        check("ext_ff_no_clear", {30'd0, seq_busy, left}, 32'd0);

        send(8'hE0);
        cycle(1'b0, 1'b0, 8'h00);
        check("busy_mid", {31'd0, seq_busy}, 32'd1);
        repeat (T + 2) cycle(1'b0, 1'b0, 8'h00);
        check("timeout_idle", {31'd0, seq_busy}, 32'd0);
        send(8'h6B); settle();
        check("timeout_discard", {31'd0, left}, 32'd0);

        send(8'hE0); send(8'h74); send(8'hE0);
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid", {28'd0, left, right, jump, seq_busy}, 32'd0);

        send(8'h1C); settle();
        check("wasd_a", {31'd0, left}, {31'd0, WASD});
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B); settle();
        check("wasd_a_keep", {31'd0, left}, {31'd0, WASD});
        send(8'hF0); send(8'h1C); settle();
        check("wasd_a_break", {31'd0, left}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r == 0) repeat (T + 3) cycle(1'b0, 1'b0, 8'h00);
            else if (r < 80) cycle(1'b0, 1'b0, 8'($urandom));
            else if (r < 190) send((r < 185) ? 8'(pool[$urandom_range(0, 11)]) : 8'($urandom));
            else cycle(1'($urandom), 1'b1, 8'(pool[$urandom_range(0, 11)]));
        end
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
